// File: rtl/fb_pkg.sv
// Shared types and sizing helpers for the framebuffer read-modify-write controller.
package fb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_MERGE,
    ST_WRITE,
    ST_DONE
  } fb_state_e;

  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX);

  function automatic int unsigned lanes_f(input int unsigned data_w, input int unsigned pix_w);
    return data_w / pix_w;
  endfunction

  function automatic int unsigned lane_log2_f(input int unsigned data_w, input int unsigned pix_w);
    return $clog2(lanes_f(data_w, pix_w));
  endfunction

endpackage

// File: rtl/fb_lane_merge.sv
// Lane operator on a RAM word: insert a pixel into one lane, or isolate one lane
// (all other lanes zeroed) for display-side extraction.
module fb_lane_merge
  import fb_pkg::*;
#(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                                    isolate_i,
  input  logic [DATA_W-1:0]                       word_i,
  input  logic [lane_log2_f(DATA_W, PIX_W)-1:0]   lane_i,
  input  logic [PIX_W-1:0]                        pix_i,
  output logic [DATA_W-1:0]                       word_o
);

  localparam int unsigned LANES     = lanes_f(DATA_W, PIX_W);
  localparam int unsigned LANE_LOG2 = lane_log2_f(DATA_W, PIX_W);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_i == LANE_LOG2'(k)) begin
        word_o[k*PIX_W +: PIX_W] = isolate_i ? word_i[k*PIX_W +: PIX_W] : pix_i;
      end else begin
        word_o[k*PIX_W +: PIX_W] = isolate_i ? '0 : word_i[k*PIX_W +: PIX_W];
      end
    end
  end

endmodule

// File: rtl/fb_rmw_controller.sv
// Framebuffer controller: scan-driven display reads plus a handshaked
// read-modify-write path that owns the RAM port while a write is in flight.
module fb_rmw_controller
  import fb_pkg::*;
#(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IMG_LOG2 = 9,
  parameter int unsigned ADDR_W   = 2 * IMG_LOG2,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         row_major,
  input  logic                                         lane_swap,
  input  logic [9:0]                                   scan_x,
  input  logic [9:0]                                   scan_y,
  output logic                                         pix_tick,
  output logic [PIX_W-1:0]                             pix_out,
  input  logic                                         wr_valid,
  output logic                                         wr_ready,
  input  logic [ADDR_W-1:0]                            wr_addr,
  input  logic [PIX_W-1:0]                             wr_pix,
  output logic                                         wr_done,
  output logic [ADDR_W-lane_log2_f(DATA_W, PIX_W)-1:0] ram_addr,
  input  logic [DATA_W-1:0]                            ram_rdata,
  output logic [DATA_W-1:0]                            ram_wdata,
  output logic                                         ram_we
);

  localparam int unsigned LANES     = lanes_f(DATA_W, PIX_W);
  localparam int unsigned LANE_LOG2 = lane_log2_f(DATA_W, PIX_W);

  fb_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [PIX_W-1:0]      wpix_q, wpix_d;
  logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;
  logic                  wr_done_q, wr_done_d;
  logic                  pix_tick_q;
  logic [PIX_W-1:0]      pix_out_q, pix_out_d;

  logic [ADDR_W-1:0]     disp_p_c;
  logic                  disp_oor_c;
  logic [LANE_LOG2-1:0]  lane_dl_q [RD_LAT];
  logic [RD_LAT-1:0]     oor_dl_q;
  logic [LANE_LOG2-1:0]  disp_lane_c;
  logic [DATA_W-1:0]     disp_iso_c;
  logic [PIX_W-1:0]      disp_pix_c;
  logic [DATA_W-1:0]     merged_c;

  // Pixel address from scan coordinates; the column-major view swaps x and y.
  assign disp_p_c = row_major ? ADDR_W'({scan_y[IMG_LOG2-1:0], scan_x[IMG_LOG2-1:0]})
                              : ADDR_W'({scan_x[IMG_LOG2-1:0], scan_y[IMG_LOG2-1:0]});
  assign disp_oor_c = ((scan_x >> IMG_LOG2) != 10'd0) || ((scan_y >> IMG_LOG2) != 10'd0);

  // Lane/blank side-band delayed to line up with ram_rdata; frozen during writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) lane_dl_q[i] <= '0;
      oor_dl_q <= '0;
    end else if (state_q == ST_IDLE) begin
      lane_dl_q[0] <= disp_p_c[LANE_LOG2-1:0];
      oor_dl_q[0]  <= disp_oor_c;
      for (int i = 1; i < RD_LAT; i++) begin
        lane_dl_q[i] <= lane_dl_q[i-1];
        oor_dl_q[i]  <= oor_dl_q[i-1];
      end
    end
  end

  assign disp_lane_c = lane_swap ? ~lane_dl_q[RD_LAT-1] : lane_dl_q[RD_LAT-1];

  fb_lane_merge #(.PIX_W(PIX_W), .DATA_W(DATA_W)) u_disp_sel (
    .isolate_i (1'b1),
    .word_i    (ram_rdata),
    .lane_i    (disp_lane_c),
    .pix_i     ({PIX_W{1'b0}}),
    .word_o    (disp_iso_c)
  );

  always_comb begin
    disp_pix_c = '0;
    for (int k = 0; k < LANES; k++) disp_pix_c = disp_pix_c | disp_iso_c[k*PIX_W +: PIX_W];
  end

  fb_lane_merge #(.PIX_W(PIX_W), .DATA_W(DATA_W)) u_wr_merge (
    .isolate_i (1'b0),
    .word_i    (ram_rdata),
    .lane_i    (waddr_q[LANE_LOG2-1:0]),
    .pix_i     (wpix_q),
    .word_o    (merged_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      waddr_q     <= '0;
      wpix_q      <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      wr_done_q   <= 1'b0;
      pix_tick_q  <= 1'b0;
      pix_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      wpix_q      <= wpix_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      wr_done_q   <= wr_done_d;
      pix_tick_q  <= ~pix_tick_q;
      pix_out_q   <= pix_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    wpix_d      = wpix_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    wr_done_d   = 1'b0;
    pix_out_d   = pix_out_q;
    case (state_q)
      ST_IDLE: begin
        pix_out_d = oor_dl_q[RD_LAT-1] ? '0 : disp_pix_c;
        if (wr_valid) begin
          waddr_d = wr_addr;
          wpix_d  = wr_pix;
          cnt_d   = '0;
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) state_d = ST_MERGE;
        else                             cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_MERGE: begin
        ram_wdata_d = merged_c;
        ram_we_d    = 1'b1;
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        wr_done_d = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The write owns the RAM port from accept until it returns to IDLE.
  assign ram_addr  = (state_q == ST_IDLE) ? disp_p_c[ADDR_W-1:LANE_LOG2]
                                          : waddr_q[ADDR_W-1:LANE_LOG2];
  assign wr_ready  = (state_q == ST_IDLE) && !reset;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign wr_done   = wr_done_q;
  assign pix_tick  = pix_tick_q;
  assign pix_out   = pix_out_q;

endmodule

// File: doc/fb_rmw_controller.md
Name: fb_rmw_controller

Overview:
- Parametrised framebuffer controller between a word-wide frame RAM, a VGA scan driver and the filter write-back path.
- Display side: turns scan coordinates into a RAM word address plus a lane, selects the pixel from the returned word, and blanks pixels outside the image.
- Write side: a handshaked read-modify-write (RMW) FSM that inserts one pixel into the correct lane of a RAM word.
- Generalises the fixed 8-bit / 32-bit / 512x512 controller: pixel width, word width, image size and RAM read latency are parameters; adds a valid/ready write handshake, a done pulse, reset, and a held display pixel while a write owns the RAM.

Parameters:
- PIX_W, 8, pixel width in bits.
- DATA_W, 32, RAM word width. Must be a power-of-two multiple of PIX_W. LANES = DATA_W/PIX_W; LANE_LOG2 = log2(LANES).
- IMG_LOG2, 9, log2 of the square image side. Image is 2^IMG_LOG2 x 2^IMG_LOG2.
- ADDR_W, 2*IMG_LOG2, pixel address width.
- RD_LAT, 2, RAM read latency in clk cycles (1..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- row_major  in  1  1: pixel address {y,x}, lane = x low bits. 0: pixel address {x,y}, lane = y low bits (transposed view).
- lane_swap  in  1  display only: 1 selects lane LANES-1-k instead of lane k.
- scan_x  in  10  scan column from the VGA driver.
- scan_y  in  10  scan row from the VGA driver.
- pix_tick  out  1  clk/2 toggle that drives the VGA pixel clock.
- pix_out  out  PIX_W  registered display pixel.
- wr_valid  in  1  write request.
- wr_ready  out  1  request accepted when wr_valid and wr_ready are both high.
- wr_addr  in  ADDR_W  pixel address of the write.
- wr_pix  in  PIX_W  pixel value to write.
- wr_done  out  1  one-cycle pulse when the RAM write has been issued.
- ram_addr  out  ADDR_W-LANE_LOG2  RAM word address.
- ram_rdata  in  DATA_W  RAM read data.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.

Behaviour:
- Reset values: FSM in IDLE; pix_tick=0, pix_out=0, ram_we=0, ram_wdata=0, wr_done=0. wr_ready=0 while reset is asserted.
- pix_tick toggles every clk.
- Display address: p = row_major ? {scan_y[IMG_LOG2-1:0], scan_x[IMG_LOG2-1:0]} : {scan_x[..], scan_y[..]}.
  - Word = p >> LANE_LOG2; lane = p[LANE_LOG2-1:0].
  - In IDLE, ram_addr = display word.
- Display data path:
  - Lane and an out-of-range flag (any scan_x or scan_y bit at or above IMG_LOG2 set) go through a delay line of RD_LAT stages, aligned with ram_rdata.
  - pix_out is registered one cycle later: 0 if out-of-range, else lane L of ram_rdata, where L = lane_swap ? LANES-1-lane : lane.
  - Lane k occupies bits [k*PIX_W +: PIX_W].
  - Latency from scan coordinates to pix_out: RD_LAT+1 clk.
- FSM states: IDLE -> RD_WAIT -> MERGE -> WRITE -> DONE -> IDLE.
  - IDLE: wr_ready=1. On wr_valid, latch wr_addr and wr_pix, then go to RD_WAIT.
  - RD_WAIT: ram_addr = latched word. Counter counts RD_LAT cycles, then go to MERGE.
  - MERGE: ram_wdata = ram_rdata with lane wr_addr[LANE_LOG2-1:0] replaced by the latched pixel. lane_swap is ignored.
  - WRITE: ram_we=1 for exactly one cycle; ram_addr = latched word.
  - DONE: wr_done=1 for one cycle, ram_we=0.
- wr_ready=0 in every state except IDLE. A new request is accepted at the earliest in the cycle after DONE.
- Accept-to-ram_we: RD_LAT+2 cycles. Accept-to-wr_done: RD_LAT+3 cycles.
- While the FSM is outside IDLE, pix_out holds its last value and the display delay line freezes.
- Simultaneous wr_valid and scan activity: the write always wins the RAM port.
- Reset mid-operation: asynchronous return to IDLE; ram_we deasserts immediately; no partial write is issued; the latched request is discarded.
- Writes at any lane are legal. The highest address, 2^ADDR_W-1, maps to the last word, top lane. No wrap.

Decomposition:
- Package fb_pkg: FSM state enum; functions lanes_f(DATA_W,PIX_W) and clog2-based LANE_LOG2; RD_LAT bound constant.
- One sub-module, fb_lane_merge (combinational): word, lane, pixel -> merged word. Reused for the display-side lane extraction via a select mode.

Test Plan:
- Reset with reset=1 mid-WRITE -> ram_we=0 in the same cycle; state IDLE; wr_ready=1 after release; RAM word unchanged.
- RAM word 0 = 0x44332211; row_major=1, scan (x=2, y=0) -> pix_out=0x33 three cycles later. With lane_swap=1 -> pix_out=0x22.
- wr_addr=0x00005, wr_pix=0xAB, RAM word 1 = 0x11223344 -> ram_we pulse at accept+4 with ram_addr=1, ram_wdata=0x1122AB44; wr_done at accept+5.
- Back-to-back writes to lanes 0 and 3 of the same word, wr_valid held high -> second accept the cycle after the first wr_done; final word contains both pixels.
- scan_x=512 (bit 9 set), scan_y=0 -> pix_out=0. row_major=0, x=1, y=6 -> ram_addr = {x,y}>>2 = 0x81, lane 2.
- Write accepted while display is running -> pix_out constant from accept through DONE; display resumes the cycle after DONE.
